// File: rtl/counter.sv
// Saturating up/down score counter, range 0..MAX_VAL.
// Registered output; async active-high reset clears to 0.
module counter #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mod_i,
  output logic [BW-1:0] counter_val_o
);

  localparam logic [BW-1:0] MAX = BW'(MAX_VAL);
  localparam logic [BW-1:0] ONE = BW'(1);
  localparam logic [BW-1:0] ZERO = '0;

  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;

  logic illegal;
  logic inc;
  logic dec;

  assign illegal = cnt_q > MAX;
  assign inc     = mod_i && (cnt_q < MAX);
  assign dec     = !mod_i && !illegal && (cnt_q != ZERO);

  // Out-of-range values (upset only) recover to MAX in either mode
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      illegal: cnt_d = MAX;
      inc:     cnt_d = cnt_q + ONE;
      dec:     cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= ZERO;
    else       cnt_q <= cnt_d;
  end

  assign counter_val_o = cnt_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed tables,
// corner sequences and a random run against an integer model.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       mod_i;
  logic [6:0] counter_val_o;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  typedef struct {
    logic mod;
    int   exp;
  } vec_t;

  vec_t tbl[6];

  counter #(.BW(7), .MAX_VAL(99)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mod_i        (mod_i),
    .counter_val_o(counter_val_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int exp);
    checks++;
    if (int'(counter_val_o) != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, counter_val_o, exp, $time);
    end
  endtask

  // Drive mode, take one edge, advance model, sample 1ns later
  task automatic step(input logic m);
    mod_i = m;
    @(posedge clk);
    #1;
    if (rst_i) model = 0;
    else if (m) model = (model + 1 > 99) ? 99 : model + 1;
    else model = (model - 1 < 0) ? 0 : model - 1;
  endtask

  // Asynchronous pulse between edges; caller is at posedge+1
  task automatic rst_pulse(input string name);
    #1;
    rst_i = 1'b1;
    #1;
    model = 0;
    chk(name, 0);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 39};
    tbl[1] = '{1'b1, 40};
    tbl[2] = '{1'b1, 41};
    tbl[3] = '{1'b0, 40};
    tbl[4] = '{1'b0, 39};
    tbl[5] = '{1'b1, 40};

    rst_i = 1'b1;
    mod_i = 1'b1;
    #1;
    chk("reset_initial", 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("reset_hold", 0);
    end

    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1);
      chk("pre_async_count", i);
    end
    rst_pulse("async_reset_midcycle");

    for (int i = 1; i <= 50; i++) begin
      step(1'b1);
      chk("count_up_50", i);
    end
    chk("count_up_50_final", 50);

    rst_pulse("reset_before_sat_hi");
    for (int i = 1; i <= 120; i++) begin
      step(1'b1);
      chk("sat_high", (i > 99) ? 99 : i);
    end
    chk("sat_high_final", 99);

    for (int i = 1; i <= 150; i++) begin
      step(1'b0);
      chk("sat_low", (99 - i < 0) ? 0 : 99 - i);
    end
    chk("sat_low_final", 0);

    rst_pulse("reset_before_reversal");
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("reach_40", 40);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].mod);
      chk($sformatf("reversal_tbl[%0d]", i), tbl[i].exp);
    end

    rst_pulse("reset_before_73");
    for (int i = 0; i < 73; i++) step(1'b1);
    chk("reach_73", 73);
    rst_pulse("async_reset_at_73");
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      chk("resume_after_reset", i);
    end

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) rst_pulse("random_reset");
      step(($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 75 : 25))
           ? 1'b1 : 1'b0);
      chk("random_model", model);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
